// File: rtl/lcd_pkg.sv
// Shared constants and state encodings for the HD44780 refresh sequencer.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_LINE1,
    ST_FETCH,
    ST_CHAR,
    ST_LINE2
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EN,
    PH_HOLD,
    PH_GAP
  } phase_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_CLEAR;
      default: return LCD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_refresh_ctrl_if.sv
// Display-buffer read port, frame request and LCD pin bundle of the refresh sequencer.
interface lcd_refresh_ctrl_if;
  logic       refresh;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic [7:0] lcd_data;
  logic       lcd_en;
  logic       lcd_rs;
  logic       init_done;
  logic       busy;

  modport master (
    input  refresh, char_data,
    output char_addr, lcd_data, lcd_en, lcd_rs, init_done, busy
  );

  modport slave (
    output refresh, char_data,
    input  char_addr, lcd_data, lcd_en, lcd_rs, init_done, busy
  );
endinterface

// File: rtl/lcd_bus_write.sv
// Timing engine for one LCD bus write: setup, enable pulse, hold, then the settle gap.
module lcd_bus_write
  import lcd_pkg::*;
#(
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 25,
  parameter int T_HOLD_CYC  = 4,
  parameter int T_CMD_CYC   = 2500,
  parameter int T_CLR_CYC   = 100_000,
  parameter int CW          = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_gap,
  output logic       done,
  output logic       idle,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  phase_t        phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rs_n;
  logic [7:0]    data_n;
  logic          long_q, long_n;

  // Enable is registered from the next phase so the pin never glitches on phase decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
      long_q   <= 1'b0;
      lcd_en   <= 1'b0;
    end else begin
      phase    <= phase_n;
      cnt      <= cnt_n;
      lcd_rs   <= rs_n;
      lcd_data <= data_n;
      long_q   <= long_n;
      lcd_en   <= (phase_n == PH_EN);
    end
  end

  always_comb begin
    phase_n = phase;
    cnt_n   = cnt;
    rs_n    = lcd_rs;
    data_n  = lcd_data;
    long_n  = long_q;
    done    = 1'b0;
    case (phase)
      PH_IDLE: begin
        if (start) begin
          phase_n = PH_SETUP;
          cnt_n   = CW'(T_SETUP_CYC - 1);
          rs_n    = rs;
          data_n  = data;
          long_n  = long_gap;
        end
      end
      PH_SETUP: begin
        if (cnt == '0) begin
          phase_n = PH_EN;
          cnt_n   = CW'(T_EN_CYC - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      PH_EN: begin
        if (cnt == '0) begin
          phase_n = PH_HOLD;
          cnt_n   = CW'(T_HOLD_CYC - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      PH_HOLD: begin
        if (cnt == '0) begin
          phase_n = PH_GAP;
          cnt_n   = long_q ? CW'(T_CLR_CYC - 1) : CW'(T_CMD_CYC - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      PH_GAP: begin
        if (cnt == '0) begin
          phase_n = PH_IDLE;
          done    = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: phase_n = PH_IDLE;
    endcase
  end

  assign idle = (phase == PH_IDLE);

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// HD44780 16x2 sequencer: power-up wait, init list, then 34-write frames on request or timer.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP_CYC    = 1_000_000,
  parameter int T_SETUP_CYC    = 4,
  parameter int T_EN_CYC       = 25,
  parameter int T_HOLD_CYC     = 4,
  parameter int T_CMD_CYC      = 2500,
  parameter int T_CLR_CYC      = 100_000,
  parameter int REFRESH_PERIOD = 0
) (
  input  logic              clk_50,
  input  logic              rst,
  lcd_refresh_ctrl_if.master bus
);

  localparam int T_MAX = max2(max2(max2(T_PWRUP_CYC, T_SETUP_CYC), max2(T_EN_CYC, T_HOLD_CYC)),
                              max2(T_CMD_CYC, T_CLR_CYC));
  localparam int CW    = $clog2(T_MAX) + 1;
  localparam int TW    = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  state_t        state, state_n;
  logic [CW-1:0] pwr_cnt, pwr_cnt_n;
  logic [1:0]    init_idx, init_idx_n;
  logic [4:0]    char_idx, char_idx_n;
  logic          pending, pending_n;
  logic [TW-1:0] timer, timer_n;
  logic          init_done, init_done_n;
  logic          expire;
  logic          wr_start, wr_rs, wr_long, wr_done, wr_idle;
  logic [7:0]    wr_data;
  logic          en_pin, rs_pin;
  logic [7:0]    data_pin;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state     <= ST_PWRUP;
      pwr_cnt   <= CW'(T_PWRUP_CYC - 1);
      init_idx  <= '0;
      char_idx  <= '0;
      pending   <= 1'b0;
      timer     <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      pwr_cnt   <= pwr_cnt_n;
      init_idx  <= init_idx_n;
      char_idx  <= char_idx_n;
      pending   <= pending_n;
      timer     <= timer_n;
      init_done <= init_done_n;
    end
  end

  // A trigger seen in IDLE, this cycle or earlier, launches the frame and is consumed in one go.
  always_comb begin
    state_n     = state;
    pwr_cnt_n   = pwr_cnt;
    init_idx_n  = init_idx;
    char_idx_n  = char_idx;
    init_done_n = init_done;
    timer_n     = timer;
    expire      = 1'b0;
    wr_start    = 1'b0;
    wr_rs       = 1'b0;
    wr_data     = 8'h00;

    if (REFRESH_PERIOD != 0 && init_done) begin
      if (timer == TW'(REFRESH_PERIOD - 1)) begin
        timer_n = '0;
        expire  = 1'b1;
      end else begin
        timer_n = timer + 1'b1;
      end
    end
    pending_n = pending | bus.refresh | expire;

    case (state)
      ST_PWRUP: begin
        if (pwr_cnt == '0) state_n = ST_INIT;
        else               pwr_cnt_n = pwr_cnt - 1'b1;
      end
      ST_INIT: begin
        wr_data  = init_cmd(init_idx);
        wr_start = wr_idle;
        if (wr_done) begin
          if (init_idx == 2'd3) begin
            state_n     = ST_IDLE;
            init_done_n = 1'b1;
            init_idx_n  = '0;
          end else begin
            init_idx_n = init_idx + 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (pending_n) begin
          state_n   = ST_LINE1;
          pending_n = 1'b0;
        end
      end
      ST_LINE1: begin
        wr_data  = LCD_LINE1;
        wr_start = wr_idle;
        if (wr_done) state_n = ST_FETCH;
      end
      ST_FETCH: state_n = ST_CHAR;
      ST_CHAR: begin
        wr_rs    = 1'b1;
        wr_data  = bus.char_data;
        wr_start = wr_idle;
        if (wr_done) begin
          char_idx_n = char_idx + 1'b1;
          if (char_idx == 5'd15)      state_n = ST_LINE2;
          else if (char_idx == 5'd31) state_n = ST_IDLE;
          else                        state_n = ST_FETCH;
        end
      end
      ST_LINE2: begin
        wr_data  = LCD_LINE2;
        wr_start = wr_idle;
        if (wr_done) state_n = ST_FETCH;
      end
      default: state_n = ST_PWRUP;
    endcase
  end

  assign wr_long = !wr_rs && (wr_data == LCD_CLEAR);

  lcd_bus_write #(
    .T_SETUP_CYC (T_SETUP_CYC),
    .T_EN_CYC    (T_EN_CYC),
    .T_HOLD_CYC  (T_HOLD_CYC),
    .T_CMD_CYC   (T_CMD_CYC),
    .T_CLR_CYC   (T_CLR_CYC),
    .CW          (CW)
  ) u_write (
    .clk      (clk_50),
    .rst      (rst),
    .start    (wr_start),
    .rs       (wr_rs),
    .data     (wr_data),
    .long_gap (wr_long),
    .done     (wr_done),
    .idle     (wr_idle),
    .lcd_en   (en_pin),
    .lcd_rs   (rs_pin),
    .lcd_data (data_pin)
  );

  assign bus.lcd_en    = en_pin;
  assign bus.lcd_rs    = rs_pin;
  assign bus.lcd_data  = data_pin;
  assign bus.char_addr = char_idx;
  assign bus.init_done = init_done;
  assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Bench for lcd_refresh_ctrl: random buffers and REFRESH timing against a write-list model.
module tb_lcd_refresh_ctrl;

  localparam int T_PWRUP  = 50;
  localparam int T_SETUP  = 2;
  localparam int T_EN     = 3;
  localparam int T_HOLD   = 2;
  localparam int T_CMD    = 10;
  localparam int T_CLR    = 20;
  localparam int PERIOD_B = 1000;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  lcd_refresh_ctrl_if if_a ();
  lcd_refresh_ctrl_if if_b ();

  lcd_refresh_ctrl #(
    .T_PWRUP_CYC(T_PWRUP), .T_SETUP_CYC(T_SETUP), .T_EN_CYC(T_EN), .T_HOLD_CYC(T_HOLD),
    .T_CMD_CYC(T_CMD), .T_CLR_CYC(T_CLR), .REFRESH_PERIOD(0)
  ) dut_a (.clk_50(clk), .rst(rst), .bus(if_a));

  lcd_refresh_ctrl #(
    .T_PWRUP_CYC(T_PWRUP), .T_SETUP_CYC(T_SETUP), .T_EN_CYC(T_EN), .T_HOLD_CYC(T_HOLD),
    .T_CMD_CYC(T_CMD), .T_CLR_CYC(T_CLR), .REFRESH_PERIOD(PERIOD_B)
  ) dut_b (.clk_50(clk), .rst(rst_b), .bus(if_b));

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] buf_a [32];
  logic [8:0] writes[$];
  logic [8:0] expected[$];
  int         rise_cyc[$];
  int         frames_b[$];
  int         init_b_cyc = -1;
  int         rst_neg = 0;

  logic       prev_en = 1'b0, prev_rs = 1'b0, have_write = 1'b0, in_reset = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [8:0] last_w = '0;
  int         chg_cyc = 0, last_rise = 0;
  logic       prev_en_b = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expect_v);
    checks++;
    if (observed !== expect_v) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, observed, expect_v, cyc);
    end
  endtask

  function automatic int gap_of(input logic [8:0] w);
    return (w == 9'h001) ? T_CLR : T_CMD;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  always @(posedge clk) if_a.char_data <= buf_a[if_a.char_addr];
  always @(posedge clk) if_b.char_data <= 8'h20 + {3'b000, if_b.char_addr};

  // Pin-level watcher on instance A: logs every write and checks the bus timing rules.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      in_reset   = 1'b1;
      have_write = 1'b0;
    end
    if ({if_a.lcd_rs, if_a.lcd_data} !== {prev_rs, prev_data}) begin
      if (have_write)
        checkOutput("rs_data_held", (cyc - last_rise) >= (T_EN + T_HOLD + gap_of(last_w)), 1'b1);
      chg_cyc = cyc;
    end
    if (if_a.lcd_en === 1'b1 && prev_en === 1'b0) begin
      checkOutput("setup_len", (cyc - chg_cyc) >= T_SETUP, 1'b1);
      last_w = {if_a.lcd_rs, if_a.lcd_data};
      writes.push_back(last_w);
      rise_cyc.push_back(cyc);
      last_rise  = cyc;
      have_write = 1'b1;
    end
    if (if_a.lcd_en === 1'b0 && prev_en === 1'b1 && !in_reset)
      checkOutput("en_width", cyc - last_rise, T_EN);
    if (!rst && if_a.lcd_en !== 1'b1) in_reset = 1'b0;
    prev_en   = if_a.lcd_en;
    prev_rs   = if_a.lcd_rs;
    prev_data = if_a.lcd_data;
  end

  initial forever begin
    @(negedge clk);
    if (if_b.lcd_en === 1'b1 && prev_en_b === 1'b0 && if_b.lcd_rs === 1'b0 && if_b.lcd_data === 8'h80)
      frames_b.push_back(cyc);
    if (init_b_cyc < 0 && if_b.init_done === 1'b1) init_b_cyc = cyc;
    prev_en_b = if_b.lcd_en;
  end

  task automatic pushInit();
    expected.push_back(9'h038);
    expected.push_back(9'h00C);
    expected.push_back(9'h001);
    expected.push_back(9'h006);
  endtask

  task automatic pushFrame();
    expected.push_back(9'h080);
    for (int i = 0; i < 16; i++) expected.push_back({1'b1, buf_a[i]});
    expected.push_back(9'h0C0);
    for (int i = 16; i < 32; i++) expected.push_back({1'b1, buf_a[i]});
  endtask

  task automatic randomBuffer();
    for (int i = 0; i < 32; i++) buf_a[i] = 8'($urandom_range(32, 126));
  endtask

  task automatic clearLog();
    writes.delete();
    rise_cyc.delete();
    expected.delete();
    pushInit();
    rst_neg = cyc;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_en", if_a.lcd_en, 1'b0);
    checkOutput("rst_rs", if_a.lcd_rs, 1'b0);
    checkOutput("rst_data", if_a.lcd_data, 8'h00);
    checkOutput("rst_addr", if_a.char_addr, 5'd0);
    checkOutput("rst_init_done", if_a.init_done, 1'b0);
    checkOutput("rst_busy", if_a.busy, 1'b1);
    rst = 1'b0;
    clearLog();
  endtask

  task automatic applyStimulus(input int delay_cyc);
    repeat (delay_cyc) @(negedge clk);
    if_a.refresh = 1'b1;
    @(negedge clk);
    if_a.refresh = 1'b0;
  endtask

  task automatic waitInitDone(output int d);
    d = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (if_a.init_done === 1'b1) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) checkOutput("init_timeout", 1'b0, 1'b1);
  endtask

  task automatic checkInit(input int d);
    if (rise_cyc.size() >= 4) begin
      checkOutput("pwrup_wait", (rise_cyc[0] - rst_neg) >= T_PWRUP &&
                                (rise_cyc[0] - rst_neg) <= T_PWRUP + T_SETUP + 8, 1'b1);
      checkOutput("init_done_lag", d - rise_cyc[3], T_EN + T_HOLD + T_CMD);
    end else begin
      checkOutput("init_writes", rise_cyc.size(), 4);
    end
    checkOutput("busy_at_init_done", if_a.busy, 1'b0);
  endtask

  task automatic waitIdle();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 6000 && quiet < 40; i++) begin
      @(negedge clk);
      if (if_a.busy === 1'b0) quiet++;
      else                    quiet = 0;
    end
    checkOutput("idle_reached", quiet >= 40, 1'b1);
  endtask

  task automatic compareWrites();
    checkOutput("write_count", writes.size(), expected.size());
    for (int i = 0; i < writes.size() && i < expected.size(); i++)
      checkOutput("write_word", writes[i], expected[i]);
  endtask

  initial begin
    int d;
    int base;
    logic found;
    if_a.refresh = 1'b0;
    if_b.refresh = 1'b0;
    randomBuffer();
    repeat (3) @(negedge clk);
    rst_b = 1'b0;

    $display("[TB] power-up and init sequence");
    doReset();
    waitInitDone(d);
    checkInit(d);
    compareWrites();

    $display("[TB] single requested frame");
    randomBuffer();
    checkOutput("idle_before", if_a.busy, 1'b0);
    applyStimulus(0);
    checkOutput("busy_next", if_a.busy, 1'b1);
    pushFrame();
    waitIdle();
    compareWrites();

    $display("[TB] coalesced requests during a frame");
    randomBuffer();
    applyStimulus(2);
    pushFrame();
    for (int k = 0; k < 3; k++) begin
      applyStimulus($urandom_range(30, 150));
      checkOutput("busy_during_pulse", if_a.busy, 1'b1);
    end
    pushFrame();
    waitIdle();
    compareWrites();

    $display("[TB] reset in the middle of a character write");
    randomBuffer();
    base = writes.size();
    applyStimulus(1);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (writes.size() >= base + 9 && if_a.lcd_en === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("char7_reached", found, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_en", if_a.lcd_en, 1'b0);
    checkOutput("abort_init_done", if_a.init_done, 1'b0);
    checkOutput("abort_busy", if_a.busy, 1'b1);
    rst = 1'b0;
    clearLog();
    waitInitDone(d);
    checkInit(d);
    repeat (300) @(negedge clk);
    checkOutput("no_resume", if_a.busy, 1'b0);
    compareWrites();

    $display("[TB] request during power-up wait");
    randomBuffer();
    doReset();
    applyStimulus($urandom_range(5, 40));
    waitInitDone(d);
    checkInit(d);
    @(negedge clk);
    checkOutput("frame_after_init", if_a.busy, 1'b1);
    pushFrame();
    waitIdle();
    compareWrites();

    $display("[TB] periodic timer frames");
    for (int i = 0; i < 8000 && frames_b.size() < 4; i++) @(negedge clk);
    checkOutput("b_frames", frames_b.size() >= 4, 1'b1);
    if (frames_b.size() >= 4) begin
      checkOutput("b_first", (frames_b[0] - init_b_cyc) >= PERIOD_B &&
                             (frames_b[0] - init_b_cyc) <= PERIOD_B + 10, 1'b1);
      for (int i = 1; i < 4; i++)
        checkOutput("b_interval", frames_b[i] - frames_b[i-1], PERIOD_B);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
